multicycle_control: RTL

Sequencing controller for the multi-cycle MIPS datapath. A Moore state machine takes the 6-bit opcode from the instruction register and steps each instruction through fetch, decode, execute, memory and writeback. Each cycle it drives the PC, memory, IR, register-file and ALU-mux controls. It replaces the single-cycle opcode decoder when the processor shares one memory and one ALU across cycles, and it stalls on a memory-ready handshake.

---
 rtl/mips_pkg.sv | 51 +++++
 rtl/multicycle_control_if.sv | 38 +++
 rtl/mc_control_decode.sv | 81 ++++++++
 rtl/multicycle_control.sv | 94 +++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS control constants: opcodes, ALUOp codes,
// multi-cycle state encodings and the control-word bundle.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ADD          = 2'b00;
  localparam logic [1:0] BRANCH_EQUAL = 2'b01;
  localparam logic [1:0] R_TYPE       = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  // mr_gate marks states whose pc_write/ir_write/retire
  // terms only fire once memory reports ready.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       retire;
    logic       mr_gate;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: Opcode/mem_ready in,
// control word, illegal_op, instr_retired and debug state out.
interface multicycle_control_if;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic       instr_retired;
  logic [3:0] state;

  modport master (
    input  Opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read,
    output mem_write, ir_write, mem_to_reg, reg_dst,
    output reg_write, alu_src_a, alu_src_b, alu_op,
    output pc_source, illegal_op, instr_retired, state
  );

  modport slave (
    output Opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read,
    input  mem_write, ir_write, mem_to_reg, reg_dst,
    input  reg_write, alu_src_a, alu_src_b, alu_op,
    input  pc_source, illegal_op, instr_retired, state
  );
endinterface

// File: rtl/mc_control_decode.sv
// Combinational state -> control word (state in, cw out).
// ADDI states decode only with MULTICYCLE_ADDI_EN.
module mc_control_decode
  import mips_pkg::*;
(
  input  state_t state,
  output ctrl_t  cw
);

  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.mem_read  = 1'b1;
        cw.alu_src_b = 2'b01;
        cw.alu_op    = ADD;
        cw.ir_write  = 1'b1;
        cw.pc_write  = 1'b1;
        cw.mr_gate   = 1'b1;
      end
      S_DECODE: begin
        cw.alu_src_b = 2'b11;
        cw.alu_op    = ADD;
      end
      S_MEMADR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = 2'b10;
        cw.alu_op    = ADD;
      end
      S_MEMRD: begin
        cw.mem_read = 1'b1;
        cw.i_or_d   = 1'b1;
      end
      S_MEMWR: begin
        cw.mem_write = 1'b1;
        cw.i_or_d    = 1'b1;
        cw.retire    = 1'b1;
        cw.mr_gate   = 1'b1;
      end
      S_MEMWB: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = 1'b1;
        cw.retire     = 1'b1;
      end
      S_EXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_op    = R_TYPE;
      end
      S_ALUWB: begin
        cw.reg_write = 1'b1;
        cw.reg_dst   = 1'b1;
        cw.retire    = 1'b1;
      end
      S_BRANCH: begin
        cw.alu_src_a     = 1'b1;
        cw.alu_op        = BRANCH_EQUAL;
        cw.pc_write_cond = 1'b1;
        cw.pc_source     = 2'b01;
        cw.retire        = 1'b1;
      end
      S_JUMP: begin
        cw.pc_write  = 1'b1;
        cw.pc_source = 2'b10;
        cw.retire    = 1'b1;
      end
`ifdef MULTICYCLE_ADDI_EN
      S_ADDIEX: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = 2'b10;
        cw.alu_op    = ADD;
      end
      S_ADDIWB: begin
        cw.reg_write = 1'b1;
        cw.retire    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: clk, rst (async high), bus (master).
// MULTICYCLE_ADDI_EN adds the ADDI path (ADDIEX -> ADDIWB).
module multicycle_control
  import mips_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  multicycle_control_if.master bus
);

  state_t state_q, state_d;
  logic   is_sw_q, is_sw_d;
  logic   illegal_op_q, illegal_op_d;
  ctrl_t  cw;
  logic   gate;

  always_comb begin
    state_d      = state_q;
    is_sw_d      = is_sw_q;
    illegal_op_d = 1'b0;
    case (state_q)
      S_FETCH:
        if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        // Remember LW vs SW so MEMADR ignores later Opcode.
        is_sw_d = (bus.Opcode == OP_SW);
        case (bus.Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          default: begin
            state_d      = S_FETCH;
            illegal_op_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:
        state_d = is_sw_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:
        if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWR:
        if (bus.mem_ready) state_d = S_FETCH;
      S_EXEC:
        state_d = S_ALUWB;
`ifdef MULTICYCLE_ADDI_EN
      S_ADDIEX:
        state_d = S_ADDIWB;
`endif
      default:
        state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      is_sw_q      <= 1'b0;
      illegal_op_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_sw_q      <= is_sw_d;
      illegal_op_q <= illegal_op_d;
    end
  end

  mc_control_decode u_decode (
    .state (state_q),
    .cw    (cw)
  );

  assign gate = (~cw.mr_gate | bus.mem_ready) & ~rst;

  assign bus.pc_write      = cw.pc_write & gate;
  assign bus.ir_write      = cw.ir_write & gate;
  assign bus.instr_retired = cw.retire & gate;
  assign bus.pc_write_cond = cw.pc_write_cond;
  assign bus.i_or_d        = cw.i_or_d;
  assign bus.mem_read      = cw.mem_read;
  assign bus.mem_write     = cw.mem_write;
  assign bus.mem_to_reg    = cw.mem_to_reg;
  assign bus.reg_dst       = cw.reg_dst;
  assign bus.reg_write     = cw.reg_write;
  assign bus.alu_src_a     = cw.alu_src_a;
  assign bus.alu_src_b     = cw.alu_src_b;
  assign bus.alu_op        = cw.alu_op;
  assign bus.pc_source     = cw.pc_source;
  assign bus.illegal_op    = illegal_op_q;
  assign bus.state         = state_q;

endmodule
